// File: rtl/eth_tx_framer_pkg.sv
// rtl/eth_tx_framer_pkg.sv - shared constants, state encoding and CRC-32 byte step for the TX framer
// Contents:
//   ETH_PREAMBLE, ETH_SFD       on-wire preamble and start-of-frame delimiter bytes
//   HDR_LEN, FCS_LEN, FLUSH_LEN byte counts of the fixed-length phases
//   CNT_W                       width of the shared byte counter
//   tx_state_e                  framer state encoding
//   crc32_byte()                one reflected CRC-32 byte update (poly 0xEDB88320)
package eth_tx_framer_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam int          HDR_LEN         = 14;
  localparam int          FCS_LEN         = 4;
  localparam int          FLUSH_LEN       = 4;
  localparam int          CNT_W           = 11;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_FLUSH,
    ST_DRAIN
  } tx_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-wide Ethernet CRC-32 calculator with FCS shift-out
// Ports:
//   clk, rst_n  byte clock, asynchronous active-low reset (register returns to all ones)
//   i_data      byte to fold into the CRC when i_vl & i_calc
//   i_vl        byte strobe; with i_calc=0 the register shifts one FCS byte out instead
//   i_calc      1 = accumulate i_data, 0 = shift out
//   o_crc32     complemented register; [7:0] is the next FCS byte to transmit
module eth_crc32
  import eth_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_vl,
  input  logic        i_calc,
  output logic [31:0] o_crc32
);

  logic [31:0] crc_q;

  // Shifting in ones means four shift-out cycles leave the register at its
  // initial all-ones value, ready for the next frame without a separate clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '1;
    end else if (i_vl) begin
      if (i_calc) begin
        crc_q <= crc32_byte(crc_q, i_data);
      end else begin
        crc_q <= {8'hFF, crc_q[31:8]};
      end
    end
  end

  assign o_crc32 = ~crc_q;

endmodule

// File: rtl/eth_tx_hdr_sreg.sv
// rtl/eth_tx_hdr_sreg.sv - 112-bit DA/SA/EtherType holding and shift-out register
// Ports:
//   clk, rst_n   byte clock, asynchronous active-low reset
//   load         capture {dst_mac, src_mac, ethertype}
//   shift        advance to the next header byte
//   dst_mac      destination MAC, MSB byte first on the wire
//   src_mac      source MAC, MSB byte first on the wire
//   ethertype    type/length, MSB byte first on the wire
//   hdr_byte     current header byte
module eth_tx_hdr_sreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic [7:0]  hdr_byte
);

  logic [111:0] sreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= {dst_mac, src_mac, ethertype};
    end else if (shift) begin
      sreg_q <= {sreg_q[103:0], 8'h00};
    end
  end

  assign hdr_byte = sreg_q[111:104];

endmodule

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - byte-wide Ethernet II TX framer feeding a CRC-32 calculator and a GMII-style PHY
// Ports:
//   clk, rst_n                         byte clock, asynchronous active-low reset
//   i_dst_mac, i_src_mac, i_ethertype  header fields, latched when a frame starts
//   i_data, i_valid, i_last, o_ready   payload byte stream (accepted on i_valid & o_ready)
//   o_crc_data, o_crc_vl, o_crc_calc   drive to CRC calculator
//   i_crc32                            CRC calculator output, [7:0] is the next FCS byte
//   o_txd, o_tx_en, o_tx_er            registered transmit byte stream
//   o_busy                             high whenever not idle
//   o_abort                            one-cycle pulse on underrun or oversize, aligned with o_tx_er
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_ethertype,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [7:0]  o_crc_data,
  output logic        o_crc_vl,
  output logic        o_crc_calc,
  input  logic [31:0] i_crc32,
  output logic [7:0]  o_txd,
  output logic        o_tx_en,
  output logic        o_tx_er,
  output logic        o_busy,
  output logic        o_abort
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             last_seen_q, last_seen_d;
  logic [7:0]       mux_byte;
  logic             mux_en, mux_er, abort;
  logic             hdr_load, hdr_shift;
  logic [7:0]       hdr_byte;
  logic             unused_crc_hi;

  // Only the low byte of the calculator output is ever transmitted.
  assign unused_crc_hi = ^i_crc32[31:8];
  assign cnt_inc       = cnt_q + 1'b1;

  eth_tx_hdr_sreg u_hdr_sreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hdr_load),
    .shift     (hdr_shift),
    .dst_mac   (i_dst_mac),
    .src_mac   (i_src_mac),
    .ethertype (i_ethertype),
    .hdr_byte  (hdr_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_seen_d = last_seen_q;
    mux_byte    = 8'h00;
    mux_en      = 1'b0;
    mux_er      = 1'b0;
    abort       = 1'b0;
    o_ready     = 1'b0;
    o_crc_vl    = 1'b0;
    o_crc_calc  = 1'b0;
    hdr_load    = 1'b0;
    hdr_shift   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The waiting byte is left on the input; it is consumed in PAYLOAD.
        if (i_valid) begin
          hdr_load    = 1'b1;
          cnt_d       = '0;
          last_seen_d = 1'b0;
          state_d     = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        mux_byte = ETH_PREAMBLE;
        mux_en   = 1'b1;
        cnt_d    = cnt_inc;
        if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_SFD;
        end
      end

      ST_SFD: begin
        mux_byte = ETH_SFD;
        mux_en   = 1'b1;
        cnt_d    = '0;
        state_d  = ST_HDR;
      end

      ST_HDR: begin
        mux_byte   = hdr_byte;
        mux_en     = 1'b1;
        o_crc_vl   = 1'b1;
        o_crc_calc = 1'b1;
        hdr_shift  = 1'b1;
        cnt_d      = cnt_inc;
        if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        o_ready    = 1'b1;
        mux_en     = 1'b1;
        o_crc_vl   = 1'b1;
        o_crc_calc = 1'b1;
        if (!i_valid || (cnt_q == CNT_W'(MAX_PAYLOAD))) begin
          // Underrun or byte MAX_PAYLOAD+1: a 0x00 byte flagged with tx_er
          // replaces it; the CRC disturbance is cleared by FLUSH.
          mux_er      = 1'b1;
          abort       = 1'b1;
          last_seen_d = i_valid & i_last;
          cnt_d       = '0;
          state_d     = ST_FLUSH;
        end else begin
          mux_byte = i_data;
          cnt_d    = cnt_inc;
          if (i_last) begin
            if (cnt_inc < CNT_W'(MIN_PAYLOAD)) begin
              state_d = ST_PAD;
            end else begin
              cnt_d   = '0;
              state_d = ST_FCS;
            end
          end
        end
      end

      ST_PAD: begin
        mux_en     = 1'b1;
        o_crc_vl   = 1'b1;
        o_crc_calc = 1'b1;
        cnt_d      = cnt_inc;
        if (cnt_inc == CNT_W'(MIN_PAYLOAD)) begin
          cnt_d   = '0;
          state_d = ST_FCS;
        end
      end

      ST_FCS: begin
        mux_byte = i_crc32[7:0];
        mux_en   = 1'b1;
        o_crc_vl = 1'b1;
        cnt_d    = cnt_inc;
        if (cnt_q == CNT_W'(FCS_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end
      end

      ST_IFG: begin
        // The IDLE cycle that follows is the last idle byte time of the gap.
        cnt_d = cnt_inc;
        if (cnt_q == CNT_W'(IFG_LEN - 2)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        o_crc_vl = 1'b1;
        cnt_d    = cnt_inc;
        if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          cnt_d   = '0;
          state_d = last_seen_q ? ST_IFG : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        o_ready = 1'b1;
        if (i_valid && i_last) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_crc_data = mux_byte;
  assign o_busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_txd   <= 8'h00;
      o_tx_en <= 1'b0;
      o_tx_er <= 1'b0;
      o_abort <= 1'b0;
    end else begin
      o_txd   <= mux_byte;
      o_tx_en <= mux_en;
      o_tx_er <= mux_er;
      o_abort <= abort;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - directed self-checking bench for eth_tx_framer paired with eth_crc32
module tb_eth_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] i_dst_mac, i_src_mac;
  logic [15:0] i_ethertype;
  logic [7:0]  i_data;
  logic        i_valid, i_last;
  logic        o_ready;
  logic [7:0]  o_crc_data;
  logic        o_crc_vl, o_crc_calc;
  logic [31:0] i_crc32;
  logic [7:0]  o_txd;
  logic        o_tx_en, o_tx_er, o_busy, o_abort;

  always #5 clk = ~clk;

  eth_tx_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_dst_mac   (i_dst_mac),
    .i_src_mac   (i_src_mac),
    .i_ethertype (i_ethertype),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_crc_data  (o_crc_data),
    .o_crc_vl    (o_crc_vl),
    .o_crc_calc  (o_crc_calc),
    .i_crc32     (i_crc32),
    .o_txd       (o_txd),
    .o_tx_en     (o_tx_en),
    .o_tx_er     (o_tx_er),
    .o_busy      (o_busy),
    .o_abort     (o_abort)
  );

  eth_crc32 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (o_crc_data),
    .i_vl    (o_crc_vl),
    .i_calc  (o_crc_calc),
    .o_crc32 (i_crc32)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent software CRC-32 (reflected, bit at a time).
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      if (((c[0] ^ b[k]) == 1'b1)) c = (c >> 1) ^ 32'hEDB88320;
      else                         c = c >> 1;
    end
    return c;
  endfunction

  logic [7:0] pay [0:1599];
  logic [7:0] exp_q[$];
  logic [7:0] cur_q[$], last_frame[$], prev_frame[$];
  int er_cnt = 0, abort_cnt = 0, er_then_en = 0, zero_run = 0, last_gap = 0;

  // Wire monitor: collects each tx_en burst as one frame.
  initial begin
    logic prev_en, prev_er;
    prev_en = 1'b0;
    prev_er = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_en) begin
        if (!prev_en) begin
          last_gap = zero_run;
          zero_run = 0;
        end
        cur_q.push_back(o_txd);
      end else begin
        zero_run++;
        if (prev_en) begin
          prev_frame = last_frame;
          last_frame = cur_q;
          cur_q.delete();
        end
      end
      if (o_tx_er) er_cnt++;
      if (prev_er && o_tx_en) er_then_en++;
      if (o_abort) abort_cnt++;
      prev_en = o_tx_en;
      prev_er = o_tx_er;
    end
  end

  function automatic logic [63:0] outs();
    return 64'({o_txd, o_tx_en, o_tx_er, o_ready, o_busy, o_abort, o_crc_vl, o_crc_calc, o_crc_data});
  endfunction

  task automatic build_exp(input int n, input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty);
    logic [31:0] c;
    int plen;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(da[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(sa[i*8 +: 8]);
    exp_q.push_back(ty[15:8]);
    exp_q.push_back(ty[7:0]);
    for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
    plen = n;
    while (plen < 46) begin
      exp_q.push_back(8'h00);
      plen++;
    end
    c = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[i*8 +: 8]);
  endtask

  function automatic logic [31:0] residue(input logic [7:0] f[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < f.size(); i++) c = crc_upd(c, f[i]);
    return c;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    int bad, n;
    bad = 0;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < n; i++) if (got[i] !== exp[i]) bad++;
    check({tag, "_bytes"}, 64'(bad), 64'd0);
  endtask

  task automatic idle_in();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 8'h00;
  endtask

  // Must be entered at a negedge; leaves the last byte driven on return.
  task automatic send(input string tag, input int len, input int gap_at, input int gap_len, input int rst_at);
    int idx, gap, guard;
    logic acc;
    idx = 0; gap = 0; guard = 0;
    while (idx < len && guard < 20000) begin
      guard++;
      if (idx == gap_at && gap < gap_len) begin
        i_valid = 1'b0;
        i_last  = 1'b0;
        gap++;
      end else begin
        i_valid = 1'b1;
        i_data  = pay[idx];
        i_last  = (idx == len - 1);
      end
      acc = o_ready && i_valid;
      if (rst_at >= 0 && idx == rst_at && acc) begin
        check({tag, "_pre_en"}, 64'(o_tx_en), 64'd1);
        #2 rst_n = 1'b0;
        #1 check({tag, "_async_rst"}, outs(), 64'd0);
        idle_in();
        @(negedge clk);
        check({tag, "_hold_rst"}, outs(), 64'd0);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (acc) idx++;
    end
    check({tag, "_drv_done"}, 64'(idx), 64'(len));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((o_busy || o_tx_en) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty);
    i_dst_mac   = da;
    i_src_mac   = sa;
    i_ethertype = ty;
  endtask

  initial begin
    int nz;
    idle_in();
    set_hdr(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800);
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), 64'd0);

    // Test 1: minimum-size frame, header inputs disturbed after latch
    for (int i = 0; i < 46; i++) pay[i] = 8'(i);
    build_exp(46, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800);
    fork
      begin
        repeat (4) @(negedge clk);
        set_hdr(48'h0, 48'hDEAD_BEEF_0000, 16'h1234);
      end
    join_none
    send("t1", 46, -1, 0, -1);
    idle_in();
    wait_idle("t1");
    check_frame("t1", last_frame, exp_q);
    check("t1_residue", 64'(residue(last_frame)), 64'h0DEBB20E3);
    check("t1_er", 64'(er_cnt), 64'd0);
    check("t1_abort", 64'(abort_cnt), 64'd0);

    // Test 2: single byte payload, 45 pad bytes
    set_hdr(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h88B5);
    pay[0] = 8'hAA;
    build_exp(1, 48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h88B5);
    send("t2", 1, -1, 0, -1);
    idle_in();
    wait_idle("t2");
    check_frame("t2", last_frame, exp_q);
    nz = 0;
    for (int i = 23; i < 68 && i < last_frame.size(); i++) if (last_frame[i] != 8'h00) nz++;
    check("t2_pad_zero", 64'(nz), 64'd0);
    if (last_frame.size() >= 72)
      check("t2_fcs", 64'({last_frame[71], last_frame[70], last_frame[69], last_frame[68]}),
            64'({exp_q[71], exp_q[70], exp_q[69], exp_q[68]}));
    else
      check("t2_fcs_len", 64'(last_frame.size()), 64'd72);

    // Test 3: maximum payload, then oversize abort
    for (int i = 0; i < 1502; i++) pay[i] = 8'(i * 7 + 3);
    build_exp(1500, 48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h88B5);
    send("t3", 1500, -1, 0, -1);
    idle_in();
    wait_idle("t3");
    check_frame("t3", last_frame, exp_q);
    check("t3_residue", 64'(residue(last_frame)), 64'h0DEBB20E3);
    er_cnt = 0; abort_cnt = 0; er_then_en = 0;
    send("t3o", 1502, -1, 0, -1);
    idle_in();
    wait_idle("t3o");
    check("t3o_abort", 64'(abort_cnt), 64'd1);
    check("t3o_er", 64'(er_cnt), 64'd1);
    check("t3o_len", 64'(last_frame.size()), 64'd1523);
    check("t3o_er_byte", 64'((last_frame.size() > 1522) ? last_frame[1522] : 8'hFF), 64'd0);
    check("t3o_er_then_en", 64'(er_then_en), 64'd0);

    // Test 4: underrun after 20 bytes, then a clean frame proves the CRC flush
    er_cnt = 0; abort_cnt = 0; er_then_en = 0;
    for (int i = 0; i < 30; i++) pay[i] = 8'hC0 + 8'(i);
    send("t4", 30, 20, 3, -1);
    idle_in();
    wait_idle("t4");
    check("t4_er", 64'(er_cnt), 64'd1);
    check("t4_abort", 64'(abort_cnt), 64'd1);
    check("t4_er_then_en", 64'(er_then_en), 64'd0);
    check("t4_len", 64'(last_frame.size()), 64'd43);
    for (int i = 0; i < 60; i++) pay[i] = 8'(8'h5A ^ 8'(i * 3));
    build_exp(60, 48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h88B5);
    send("t4c", 60, -1, 0, -1);
    idle_in();
    wait_idle("t4c");
    check_frame("t4c", last_frame, exp_q);
    check("t4c_residue", 64'(residue(last_frame)), 64'h0DEBB20E3);

    // Test 5: back-to-back frames with i_valid held high
    for (int i = 0; i < 50; i++) pay[i] = 8'(255 - i);
    build_exp(50, 48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h88B5);
    send("t5a", 50, -1, 0, -1);
    send("t5b", 50, -1, 0, -1);
    idle_in();
    wait_idle("t5");
    check_frame("t5a", prev_frame, exp_q);
    check_frame("t5b", last_frame, exp_q);
    check("t5_gap", 64'(last_gap), 64'd12);

    // Test 6: reset during payload, then a clean frame
    for (int i = 0; i < 80; i++) pay[i] = 8'h81 + 8'(i);
    send("t6", 80, -1, 0, 10);
    wait_idle("t6");
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 5 + 1);
    build_exp(64, 48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h88B5);
    send("t6c", 64, -1, 0, -1);
    idle_in();
    wait_idle("t6c");
    check_frame("t6c", last_frame, exp_q);
    check("t6c_residue", 64'(residue(last_frame)), 64'h0DEBB20E3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
